// File: rtl/module_name_pkg.sv
// module_name_pkg: shared width default and the two-term sum-of-products cell function
package module_name_pkg;
  localparam int DEFAULT_WIDTH = 1;
  function automatic logic sop2(input logic a, input logic b, input logic c, input logic d);
    return (a & c) | (b & d);
  endfunction
endpackage

// File: rtl/module_name_ac_bd_sop2_lane.sv
// sop2_lane: single-bit combinational (a&c)|(b&d) cell
module sop2_lane
  import module_name_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic z
);
  assign z = sop2(a, b, c, d);
endmodule

// File: rtl/module_name_ac_bd.sv
// module_name_ac_bd: registered Z = (A&C)|(B&D) per lane with a one-cycle change pulse
// MODULE_NAME_INPUT_REG_EN adds an input register stage (latency 2 instead of 1)
module module_name_ac_bd
  import module_name_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Z,
  output logic             z_chg
);
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q, next_z;
`ifdef MODULE_NAME_INPUT_REG_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= A;
      b_q <= B;
      c_q <= C;
      d_q <= D;
    end
`else
  assign a_q = A;
  assign b_q = B;
  assign c_q = C;
  assign d_q = D;
`endif
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sop2_lane u_lane (.a(a_q[i]), .b(b_q[i]), .c(c_q[i]), .d(d_q[i]), .z(next_z[i]));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      Z     <= '0;
      z_chg <= 1'b0;
    end else begin
      Z     <= next_z;
      z_chg <= next_z != Z;
    end
endmodule

// File: tb/tb_module_name_ac_bd.sv
// tb_module_name_ac_bd: directed known-answer bench for module_name_ac_bd at WIDTH=4
module tb_module_name_ac_bd;
  localparam int W = 4;
`ifdef MODULE_NAME_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] A, B, C, D, Z;
  logic z_chg;
  int n_tests = 0, n_fail = 0;
  module_name_ac_bd #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D), .Z(Z), .z_chg(z_chg)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // vectors {A,B,C,D,expected Z}, expectations worked by hand
  logic [W-1:0] va [7] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'ha, 4'h0};
  logic [W-1:0] vb [7] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h5, 4'h0};
  logic [W-1:0] vc [7] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'hc, 4'h0};
  logic [W-1:0] vd [7] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h3, 4'h0};
  logic [W-1:0] ve [7] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h9, 4'h0};
  initial begin
    logic [W-1:0] prev;
    {A, B, C, D} = '1;
    repeat (2) step();
    check("rst_z", Z, 0);
    check("rst_chg", z_chg, 0);
    rst = 1'b0;
    repeat (LAT) step();
    check("pre_z", Z, 4'hf);
    check("pre_chg", z_chg, 1);
    step();
    check("pre_chg_clr", z_chg, 0);
    #2 rst = 1'b1;
    #1;
    check("async_z", Z, 0);
    check("async_chg", z_chg, 0);
    repeat (3) begin
      step();
      check("hold_rst_z", Z, 0);
      check("hold_rst_chg", z_chg, 0);
    end
    {A, B, C, D} = '0;
    step();
    rst = 1'b0;
    prev = '0;
    for (int i = 0; i < 7; i++) begin
      A = va[i]; B = vb[i]; C = vc[i]; D = vd[i];
      for (int k = 0; k < LAT - 1; k++) begin
        step();
        check("latency_hold_z", Z, prev);
        check("latency_hold_chg", z_chg, 0);
      end
      step();
      check($sformatf("z_v%0d", i), Z, ve[i]);
      check($sformatf("chg_v%0d", i), z_chg, ve[i] != prev);
      step();
      check($sformatf("z_stable_v%0d", i), Z, ve[i]);
      check($sformatf("chg_clr_v%0d", i), z_chg, 0);
      prev = ve[i];
    end
    A = 4'hf; B = 4'hf; C = 4'hf; D = 4'hf;
    step();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    {A, B, C, D} = '0;
    repeat (LAT + 1) begin
      step();
      check("flush_z", Z, 0);
      check("flush_chg", z_chg, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
